// File: rtl/ft_fifo_emu_pkg.sv
// Shared types and constants for the FT-style FIFO emulator.
package ft_fifo_emu_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        PWR   = 2'd0,
        PGAP1 = 2'd1,
        PRD   = 2'd2,
        PGAP2 = 2'd3
    } pat_state_e;

    typedef enum logic {
        MODE_PATTERN  = 1'b0,
        MODE_LOOPBACK = 1'b1
    } mode_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/ft_emu_fifo.sv
// Loopback buffer: first-word fall-through FIFO with registered occupancy and full/empty flags.
module ft_emu_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    assign rd_data_o = mem_q[rd_ptr_q];

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ft_fifo_emu.sv
// FT245-style synchronous FIFO device emulator: pattern generator/checker or loopback buffer.
// Optional byte-enable lanes are enabled by defining FT_FIFO_EMU_BE_EN.
module ft_fifo_emu
    import ft_fifo_emu_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned XFER_LEN = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    output logic               rxf_n,
    input  logic               oe_n,
    input  logic               rd_n,
    input  logic [DATA_W-1:0]  data_in,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_oe,
    output logic               txe_n,
    input  logic               wr_n,
    output logic [15:0]        word_cnt,
    output logic [15:0]        err_cnt,
    output logic               ovf,
    output logic               udf
`ifdef FT_FIFO_EMU_BE_EN
    ,
    input  logic [DATA_W/8-1:0] be_n_in,
    output logic [DATA_W/8-1:0] be_n_out
`endif
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XFER_LEN);
`ifdef FT_FIFO_EMU_BE_EN
    localparam int unsigned FW = DATA_W + NB;
`else
    localparam int unsigned FW = DATA_W;
`endif

    mode_e            mode_q;
    logic             init_q;
    pat_state_e       state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             loopback;
    logic             pat_txe_n, pat_rxf_n;
    logic             wr_acc, rd_acc;
    logic [DATA_W-1:0] exp_w;
    logic [NB-1:0]    be_n_w;
    logic             mism;

    logic             fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [FW-1:0]    fifo_din, fifo_dout;
    logic [AW:0]      fifo_count;

    assign loopback = (mode_q == MODE_LOOPBACK);

`ifdef FT_FIFO_EMU_BE_EN
    assign be_n_w   = be_n_in;
    assign fifo_din = {be_n_in, data_in};
    assign be_n_out = loopback ? fifo_dout[FW-1:DATA_W] : '0;
`else
    assign be_n_w   = '0;
    assign fifo_din = data_in;
`endif

    ft_emu_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_din),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_dout),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // init_q keeps both flags deasserted for the first cycle after reset in loopback.
    assign txe_n   = loopback ? (fifo_full  || init_q) : pat_txe_n;
    assign rxf_n   = loopback ? (fifo_empty || init_q) : pat_rxf_n;
    assign data_oe = !oe_n;

    assign wr_acc  = !wr_n && !txe_n;
    assign rd_acc  = !rd_n && !rxf_n;
    assign fifo_wr = loopback && wr_acc;
    assign fifo_rd = loopback && rd_acc;

    assign exp_w = DATA_W'(word_cnt_q);

    always_comb begin
        mism = 1'b0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (!be_n_w[b] && (data_in[8*b +: 8] != exp_w[8*b +: 8])) begin
                mism = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PGAP2;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!loopback) begin
            case (state_q)
                PWR:   if (wr_acc && (word_cnt_q + CNT_W'(1) == LAST)) state_d = PGAP1;
                PGAP1: state_d = PRD;
                PRD:   if (rd_acc && (word_cnt_q + CNT_W'(1) == LAST)) state_d = PGAP2;
                PGAP2: state_d = PWR;
                default: state_d = PGAP2;
            endcase
        end
    end

    always_comb begin
        pat_txe_n = (state_q != PWR);
        pat_rxf_n = (state_q != PRD);
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        ovf_d      = ovf_q || (!wr_n && txe_n);
        udf_d      = udf_q || (!rd_n && rxf_n);
        if (!loopback) begin
            case (state_q)
                PWR: begin
                    if (wr_acc) begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        if (mism) begin
                            err_cnt_d = sat_inc(err_cnt_q);
                        end
                    end
                end
                PRD: begin
                    if (rd_acc) begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
                default: word_cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= mode_e'(mode);
            init_q     <= 1'b1;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            init_q     <= 1'b0;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    always_comb begin
        data_out = '0;
        if (loopback) begin
            if (!rxf_n) begin
                data_out = fifo_dout[DATA_W-1:0];
            end
        end else if (state_q == PRD) begin
            data_out = exp_w;
        end
    end

    assign word_cnt = loopback ? CNT_W'(fifo_count) : word_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;

endmodule

// File: tb/tb_ft_fifo_emu.sv
// Directed bench: pattern bursts and mid-burst reset on an 8-bit instance,
// loopback fill/overflow/underflow on the same instance, streaming loopback on a 32-bit instance.
module tb_ft_fifo_emu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic        rst_a, mode_a, oe_n_a, rd_n_a, wr_n_a;
    logic [7:0]  din_a, dout_a;
    logic        rxf_n_a, txe_n_a, doe_a, ovf_a, udf_a;
    logic [15:0] wc_a, ec_a;

    // 32-bit instance
    logic        rst_b, mode_b, oe_n_b, rd_n_b, wr_n_b;
    logic [31:0] din_b, dout_b;
    logic        rxf_n_b, txe_n_b, doe_b, ovf_b, udf_b;
    logic [15:0] wc_b, ec_b;

    ft_fifo_emu #(.DATA_W(8), .DEPTH(16), .XFER_LEN(20)) u_dut_a (
        .clk(clk), .rst(rst_a), .mode(mode_a), .rxf_n(rxf_n_a), .oe_n(oe_n_a),
        .rd_n(rd_n_a), .data_in(din_a), .data_out(dout_a), .data_oe(doe_a),
        .txe_n(txe_n_a), .wr_n(wr_n_a), .word_cnt(wc_a), .err_cnt(ec_a),
        .ovf(ovf_a), .udf(udf_a)
    );

    ft_fifo_emu #(.DATA_W(32), .DEPTH(16), .XFER_LEN(20)) u_dut_b (
        .clk(clk), .rst(rst_b), .mode(mode_b), .rxf_n(rxf_n_b), .oe_n(oe_n_b),
        .rd_n(rd_n_b), .data_in(din_b), .data_out(dout_b), .data_oe(doe_b),
        .txe_n(txe_n_b), .wr_n(wr_n_b), .word_cnt(wc_b), .err_cnt(ec_b),
        .ovf(ovf_b), .udf(udf_b)
    );

    typedef struct {
        logic        wr_n;
        logic        rd_n;
        logic [7:0]  din;
        logic        txe_n;
        logic        rxf_n;
        logic [7:0]  dout;
        logic [15:0] wc;
        logic [15:0] ec;
    } vec_t;

    vec_t vt[$];
    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(input logic w, input logic r, input int d, input logic t,
                                input logic x, input int o, input int c, input int e);
        vec_t v;
        v.wr_n = w; v.rd_n = r; v.din = 8'(d); v.txe_n = t; v.rxf_n = x;
        v.dout = 8'(o); v.wc = 16'(c); v.ec = 16'(e);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_a();
        chk("rst_txe_n", 32'(txe_n_a), 32'd1);
        chk("rst_rxf_n", 32'(rxf_n_a), 32'd1);
        chk("rst_dout",  32'(dout_a),  32'd0);
        chk("rst_wc",    32'(wc_a),    32'd0);
        chk("rst_ec",    32'(ec_a),    32'd0);
        chk("rst_ovf",   32'(ovf_a),   32'd0);
        chk("rst_udf",   32'(udf_a),   32'd0);
    endtask

    function automatic logic [31:0] bval(input int i);
        return 32'hC0DE_0000 + 32'(i * 32'h0001_0101);
    endfunction

    initial begin
        // Pattern-mode vector table: inputs applied before an edge, outputs expected after it.
        for (int i = 0; i < 20; i++) vt.push_back(mk(0, 1, i, (i == 19), 1, 0, i + 1, 0));
        vt.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0));
        for (int k = 0; k < 20; k++) vt.push_back(mk(1, 0, 0, 1, (k == 19), k + 1, k + 1, 0));
        vt.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 20; i++)
            vt.push_back(mk(0, 1, (i == 3) ? 5 : i, (i == 19), 1, 0, i + 1, (i >= 3) ? 1 : 0));
        vt.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1));
        for (int k = 0; k < 10; k++) vt.push_back(mk(1, 0, 0, 1, 0, k + 1, k + 1, 1));

        rst_a = 1'b1; mode_a = 1'b0; oe_n_a = 1'b1; rd_n_a = 1'b1; wr_n_a = 1'b1; din_a = '0;
        rst_b = 1'b1; mode_b = 1'b1; oe_n_b = 1'b1; rd_n_b = 1'b1; wr_n_b = 1'b1; din_b = '0;
        tick();
        tick();
        chk_reset_a();
        chk("data_oe_off", 32'(doe_a), 32'd0);
        oe_n_a = 1'b0;
        #1;
        chk("data_oe_on", 32'(doe_a), 32'd1);
        rst_a = 1'b0;
        tick();
        chk("pwr_txe_n", 32'(txe_n_a), 32'd0);
        chk("pwr_wc0",   32'(wc_a),    32'd0);

        foreach (vt[n]) begin
            wr_n_a = vt[n].wr_n;
            rd_n_a = vt[n].rd_n;
            din_a  = vt[n].din;
            tick();
            chk($sformatf("v%0d_txe_n", n), 32'(txe_n_a), 32'(vt[n].txe_n));
            chk($sformatf("v%0d_rxf_n", n), 32'(rxf_n_a), 32'(vt[n].rxf_n));
            chk($sformatf("v%0d_wc", n),    32'(wc_a),    32'(vt[n].wc));
            chk($sformatf("v%0d_ec", n),    32'(ec_a),    32'(vt[n].ec));
            if (vt[n].rxf_n == 1'b0)
                chk($sformatf("v%0d_dout", n), 32'(dout_a), 32'(vt[n].dout));
        end
        chk("pat_ovf", 32'(ovf_a), 32'd0);
        chk("pat_udf", 32'(udf_a), 32'd0);

        // Reset at word 10 of the read burst, then a fresh write burst from word 0.
        wr_n_a = 1'b1; rd_n_a = 1'b1; rst_a = 1'b1;
        tick();
        chk_reset_a();
        rst_a = 1'b0;
        tick();
        chk("post_rst_txe_n", 32'(txe_n_a), 32'd0);
        chk("post_rst_rxf_n", 32'(rxf_n_a), 32'd1);
        chk("post_rst_wc",    32'(wc_a),    32'd0);
        wr_n_a = 1'b0; din_a = 8'd0;
        tick();
        wr_n_a = 1'b1;
        chk("fresh_wc", 32'(wc_a), 32'd1);
        chk("fresh_ec", 32'(ec_a), 32'd0);

        // Loopback on the 8-bit instance.
        mode_a = 1'b1; rst_a = 1'b1;
        tick();
        chk("lb_rst_txe_n", 32'(txe_n_a), 32'd1);
        chk("lb_rst_rxf_n", 32'(rxf_n_a), 32'd1);
        rst_a = 1'b0;
        tick();
        chk("lb_txe_n0", 32'(txe_n_a), 32'd0);
        rd_n_a = 1'b0;
        tick();
        rd_n_a = 1'b1;
        chk("lb_udf",     32'(udf_a),   32'd1);
        chk("lb_udf_wc",  32'(wc_a),    32'd0);
        chk("lb_udf_rxf", 32'(rxf_n_a), 32'd1);
        for (int i = 0; i < 16; i++) begin
            wr_n_a = 1'b0; din_a = 8'hA0 + 8'(i);
            tick();
            chk($sformatf("lb_fill%0d_wc", i),  32'(wc_a),    32'(i + 1));
            chk($sformatf("lb_fill%0d_txe", i), 32'(txe_n_a), 32'(i == 15));
            chk($sformatf("lb_fill%0d_rxf", i), 32'(rxf_n_a), 32'd0);
            if (i == 0) chk("lb_fwft_head", 32'(dout_a), 32'hA0);
        end
        din_a = 8'hEE;
        tick();
        wr_n_a = 1'b1;
        chk("lb_ovf",    32'(ovf_a), 32'd1);
        chk("lb_ovf_wc", 32'(wc_a),  32'd16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("lb_rd%0d_dout", k), 32'(dout_a), 32'hA0 + 32'(k));
            rd_n_a = 1'b0;
            tick();
            chk($sformatf("lb_rd%0d_wc", k), 32'(wc_a), 32'(15 - k));
        end
        rd_n_a = 1'b1;
        chk("lb_empty_rxf", 32'(rxf_n_a), 32'd1);
        chk("lb_ovf_sticky", 32'(ovf_a), 32'd1);
        chk("lb_udf_sticky", 32'(udf_a), 32'd1);
        chk("lb_ec", 32'(ec_a), 32'd0);

        // 32-bit loopback: fill to 8, then stream with simultaneous read and write.
        rst_b = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            wr_n_b = 1'b0; din_b = bval(i);
            tick();
        end
        chk("b_occ8", 32'(wc_b), 32'd8);
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("b_s%0d_dout", k), dout_b, bval(k));
            wr_n_b = 1'b0; rd_n_b = 1'b0; din_b = bval(k + 8);
            tick();
            chk($sformatf("b_s%0d_wc", k), 32'(wc_b), 32'd8);
        end
        wr_n_b = 1'b1; rd_n_b = 1'b1;
        chk("b_tail_dout", dout_b, bval(24));
        chk("b_ovf", 32'(ovf_b), 32'd0);
        chk("b_udf", 32'(udf_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
